// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a 16-bit-address serial SRAM (READ 0x03 / WRITE 0x02) in front of a strobe memory port.
// Build option: define SPI_RESP_SEQ_EN for sequential burst reads/writes; otherwise one data byte per frame.
module spi_sram_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              cmd_err,
    output logic [2:0]        dbg_state_o
);

    localparam int CNT_W = $clog2((ADDR_W > 8) ? ADDR_W : 8);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CMD        = 3'd1,
        ADDR       = 3'd2,
        READ_FETCH = 3'd3,
        READ_LOAD  = 3'd4,
        READ_DATA  = 3'd5,
        WRITE_DATA = 3'd6,
        IGNORE     = 3'd7
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [7:0]             shift_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   is_read_q;
    logic                   miso_q;
    logic                   miso_oe_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [7:0]             mem_wdata_q;
    logic                   mem_we_q;
    logic                   mem_re_q;
    logic                   cmd_err_q;

    logic                   sclk_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   rise;
    logic                   fall;
    logic [7:0]             byte_d;
    logic [ADDR_W-1:0]      addr_shift_d;
    logic [ADDR_W-1:0]      addr_inc_d;
    logic                   last_bit;

    // cs synchronizer resets to the deasserted level so busy is 0 in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s       = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s         = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_sync_q[SYNC_STAGES-1];
    assign rise         = sclk_s & ~sclk_prev_q;
    assign fall         = ~sclk_s & sclk_prev_q;
    assign byte_d       = {shift_q[6:0], mosi_s};
    assign addr_shift_d = {addr_q[ADDR_W-2:0], mosi_s};
    assign addr_inc_d   = addr_q + ADDR_W'(1);
    assign last_bit     = (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            mem_we_q  <= 1'b0;
            mem_re_q  <= 1'b0;
            cmd_err_q <= 1'b0;
            if (cs_s) begin
                state_q   <= IDLE;
                cnt_q     <= '0;
                miso_q    <= 1'b0;
                miso_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= CMD;
                        cnt_q   <= CNT_W'(7);
                        shift_q <= '0;
                    end
                    CMD: begin
                        if (rise) begin
                            shift_q <= byte_d;
                            cnt_q   <= cnt_q - CNT_W'(1);
                            if (last_bit) begin
                                if (byte_d == 8'h02 || byte_d == 8'h03) begin
                                    is_read_q <= byte_d[0];
                                    cnt_q     <= CNT_W'(ADDR_W - 1);
                                    state_q   <= ADDR;
                                end else begin
                                    cmd_err_q <= 1'b1;
                                    state_q   <= IGNORE;
                                end
                            end
                        end
                    end
                    ADDR: begin
                        if (rise) begin
                            addr_q <= addr_shift_d;
                            cnt_q  <= cnt_q - CNT_W'(1);
                            if (last_bit) begin
                                cnt_q <= CNT_W'(7);
                                if (is_read_q) begin
                                    mem_re_q   <= 1'b1;
                                    mem_addr_q <= addr_shift_d;
                                    state_q    <= READ_FETCH;
                                end else begin
                                    state_q <= WRITE_DATA;
                                end
                            end
                        end
                    end
                    // mem_re is high during READ_FETCH; mem_rdata is valid during READ_LOAD.
                    READ_FETCH: state_q <= READ_LOAD;
                    READ_LOAD: begin
                        shift_q   <= mem_rdata;
                        miso_q    <= mem_rdata[7];
                        miso_oe_q <= 1'b1;
                        cnt_q     <= CNT_W'(7);
                        state_q   <= READ_DATA;
                    end
                    READ_DATA: begin
                        if (rise) begin
                            cnt_q <= cnt_q - CNT_W'(1);
                            if (last_bit) begin
`ifdef SPI_RESP_SEQ_EN
                                addr_q     <= addr_inc_d;
                                mem_re_q   <= 1'b1;
                                mem_addr_q <= addr_inc_d;
                                state_q    <= READ_FETCH;
`else
                                miso_q    <= 1'b0;
                                miso_oe_q <= 1'b0;
                                state_q   <= IGNORE;
`endif
                            end
                        end else if (fall && cnt_q != CNT_W'(7)) begin
                            // The fall preceding the first rise of a byte must keep bit 7 on the pin.
                            shift_q <= {shift_q[6:0], 1'b0};
                            miso_q  <= shift_q[6];
                        end
                    end
                    WRITE_DATA: begin
                        if (rise) begin
                            shift_q <= byte_d;
                            cnt_q   <= cnt_q - CNT_W'(1);
                            if (last_bit) begin
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= byte_d;
                                mem_addr_q  <= addr_q;
`ifdef SPI_RESP_SEQ_EN
                                addr_q  <= addr_inc_d;
                                cnt_q   <= CNT_W'(7);
`else
                                state_q <= IGNORE;
`endif
                            end
                        end
                    end
                    IGNORE: begin
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign miso        = miso_q & miso_oe_q;
    assign miso_oe     = miso_oe_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign cmd_err     = cmd_err_q;
    assign busy        = ~cs_s;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Bench for spi_sram_responder: table of SPI frames plus abort, burst and mid-read reset sequences.
// Memory strobes are checked against scoreboard queues filled when each frame is driven.
module tb_spi_sram_responder;
  localparam int SYNC = 2;
  localparam int H    = 6;

  logic        clk = 1'b0;
  logic        rst, sclk, cs, mosi;
  logic        miso, miso_oe, mem_we, mem_re, busy, cmd_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;

  spi_sram_responder #(.SYNC_STAGES(SYNC), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .busy(busy), .cmd_err(cmd_err), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int we_cnt, re_cnt, err_cnt, oe_cnt, viol_cnt;
  logic [23:0] exp_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  rd_value = 8'h00;

  typedef struct {
    int          kind;   // 0 write, 1 read, 2 bad command
    logic [7:0]  cmd;
    logic [15:0] addr;
    logic [7:0]  data;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: registered read data, valid one clk after mem_re, zero otherwise.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= rd_value;
    else        mem_rdata <= 8'h00;
  end

  // Monitor and scoreboard for the memory side.
  always @(negedge clk) begin
    if (!rst) begin
      if (miso_oe) oe_cnt++;
      if (cmd_err) err_cnt++;
      if ((miso && !miso_oe) || (mem_we && mem_re)) viol_cnt++;
      if (mem_we) begin
        we_cnt++;
        if (exp_q.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF_FFFF);
        else chk("mem_write", {mem_addr, mem_wdata}, exp_q.pop_front());
      end
      if (mem_re) begin
        re_cnt++;
        if (exp_rd_q.size() == 0) chk("unexpected_read", mem_addr, 32'hFFFF_FFFF);
        else chk("mem_read_addr", mem_addr, exp_rd_q.pop_front());
      end
    end
  end

  task automatic clear_mon();
    we_cnt = 0; re_cnt = 0; err_cnt = 0; oe_cnt = 0; viol_cnt = 0;
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      repeat (H) @(negedge clk);
      rx = {rx[6:0], miso};
      sclk = 1'b1;
      repeat (H) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] cmd, input logic [15:0] addr, input int nbytes,
                       input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                       output logic [7:0] rx0);
    logic [7:0] r;
    rx0 = 8'h00;
    @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(cmd, 8, r);
    spi_bits(addr[15:8], 8, r);
    spi_bits(addr[7:0], 8, r);
    for (int b = 0; b < nbytes; b++) begin
      spi_bits((b == 0) ? d0 : (b == 1) ? d1 : d2, 8, r);
      if (b == 0) rx0 = r;
    end
    repeat (H) @(negedge clk);
    cs = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_miso"}, miso, 0);
    chk({tag, "_miso_oe"}, miso_oe, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_re"}, mem_re, 0);
    chk({tag, "_cmd_err"}, cmd_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int n;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (4) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_busy", busy, 0);
    chk("idle_state", dbg_state, 0);

    vecs[0] = '{0, 8'h02, 16'h1234, 8'hA5};
    vecs[1] = '{1, 8'h03, 16'h0010, 8'h3C};
    vecs[2] = '{2, 8'h9F, 16'h0000, 8'h00};
    vecs[3] = '{0, 8'h02, 16'h0000, 8'h5A};
    vecs[4] = '{1, 8'h03, 16'hFFFF, 8'hC3};
    vecs[5] = '{2, 8'h00, 16'h1111, 8'h22};
    vecs[6] = '{2, 8'hFF, 16'hFFFF, 8'hFF};
    vecs[7] = '{0, 8'h02, 16'hABCD, 8'hFF};
    vecs[8] = '{0, 8'h02, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255))};
    vecs[9] = '{1, 8'h03, 16'($urandom_range(0, 65535)), 8'($urandom_range(0, 255))};

    for (int v = 0; v < 10; v++) begin
      clear_mon();
      rd_value = vecs[v].data;
      if (vecs[v].kind == 0) exp_q.push_back({vecs[v].addr, vecs[v].data});
      if (vecs[v].kind == 1) begin
        exp_rd_q.push_back(vecs[v].addr);
`ifdef SPI_RESP_SEQ_EN
        exp_rd_q.push_back(vecs[v].addr + 16'd1);
`endif
      end
      frame(vecs[v].cmd, vecs[v].addr, 1, vecs[v].data, 8'h00, 8'h00, rx);
      chk($sformatf("v%0d_we_cnt", v), we_cnt, (vecs[v].kind == 0) ? 1 : 0);
      chk($sformatf("v%0d_err_cnt", v), err_cnt, (vecs[v].kind == 2) ? 1 : 0);
      chk($sformatf("v%0d_oe_seen", v), oe_cnt != 0, vecs[v].kind == 1);
      chk($sformatf("v%0d_violations", v), viol_cnt, 0);
      chk($sformatf("v%0d_pending", v), exp_q.size() + exp_rd_q.size(), 0);
      chk($sformatf("v%0d_end_state", v), dbg_state, 0);
      if (vecs[v].kind == 1) chk($sformatf("v%0d_miso_byte", v), rx, vecs[v].data);
      else chk($sformatf("v%0d_re_cnt", v), re_cnt, 0);
    end

    // Abort a write after 4 data bits.
    clear_mon();
    @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(8'h02, 8, rx);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'hF0, 4, rx);
    cs = 1'b1;
    n = 0;
    while ((busy || dbg_state != 3'd0) && n < SYNC + 1) begin
      @(negedge clk);
      n++;
    end
    chk("abort_idle_in_time", {31'd0, busy || dbg_state != 3'd0}, 0);
    repeat (10) @(negedge clk);
    chk("abort_no_write", we_cnt, 0);
    chk("abort_violations", viol_cnt, 0);

    // Write burst across the top of the address space.
    clear_mon();
    exp_q.push_back({16'hFFFF, 8'h11});
`ifdef SPI_RESP_SEQ_EN
    exp_q.push_back({16'h0000, 8'h22});
    exp_q.push_back({16'h0001, 8'h33});
`endif
    frame(8'h02, 16'hFFFF, 3, 8'h11, 8'h22, 8'h33, rx);
`ifdef SPI_RESP_SEQ_EN
    chk("burst_we_cnt", we_cnt, 3);
`else
    chk("burst_we_cnt", we_cnt, 1);
`endif
    chk("burst_pending", exp_q.size(), 0);
    chk("burst_err", err_cnt, 0);

    // Reset in the middle of a read data byte.
    clear_mon();
    rd_value = 8'h3C;
    exp_rd_q.push_back(16'h0010);
    @(negedge clk);
    cs = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(8'h03, 8, rx);
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h10, 8, rx);
    spi_bits(8'h00, 3, rx);
    chk("pre_rst_oe", miso_oe, 1);
    chk("pre_rst_bits", rx[2:0], 3'b001);
    rst = 1'b1;
    @(negedge clk);
    chk_outputs_zero("mid_rst");
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    clear_mon();
    exp_rd_q.delete();
    exp_rd_q.push_back(16'h0010);
`ifdef SPI_RESP_SEQ_EN
    exp_rd_q.push_back(16'h0011);
`endif
    frame(8'h03, 16'h0010, 1, 8'h00, 8'h00, 8'h00, rx);
    chk("post_rst_miso_byte", rx, 8'h3C);
    chk("post_rst_pending", exp_rd_q.size(), 0);
    chk("post_rst_we", we_cnt, 0);
    chk("post_rst_violations", viol_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
